// File: rtl/pal_macrocell_fabric.sv
// Purpose: AND/OR PAL fabric with per-output macrocells, serially loaded config committed atomically per frame.
// Latency: combinational outputs zero-cycle, registered outputs one cycle; config commits on the edge taking the last bit.
// Backpressure: none; cfg_en low stalls the loader indefinitely, and the fabric keeps running the active config meanwhile.
module pal_macrocell_fabric #(
    parameter int N = 8,
    parameter int M = 4,
    parameter int P = 13
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic         cfg_en,
    input  logic         cfg_bit,
    input  logic         run_en,
    input  logic [N-1:0] INPUT_VARS,
    output logic [M-1:0] OUTPUT_VALS,
    output logic         cfg_busy,
    output logic         cfg_done
);
    localparam int V       = N + M;
    localparam int A       = P * 2 * V;
    localparam int B       = A + M * P;
    localparam int CFG_LEN = B + 2 * M;
    localparam int CW      = $clog2(CFG_LEN);

    logic [CFG_LEN-1:0] shadow;
    logic [CFG_LEN-1:0] shadow_nxt;
    logic [CFG_LEN-1:0] active;
    logic [CW-1:0]      cnt;
    logic               last;
    logic               commit;
    logic [M-1:0]       flops;
    logic [V-1:0]       vars;
    logic [P-1:0]       prod;
    logic [P-1:0]       lit_any;
    logic [M-1:0]       sum;

    assign last       = (cnt == CW'(CFG_LEN - 1));
    assign commit     = cfg_en & last;
    assign shadow_nxt = {cfg_bit, shadow[CFG_LEN-1:1]};
    assign cfg_busy   = (cnt != '0);

    // Loader: the active config takes the shadow including the bit accepted on the same edge.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            shadow   <= '0;
            active   <= '0;
            cnt      <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= commit;
            if (cfg_en) begin
                shadow <= shadow_nxt;
                cnt    <= last ? '0 : cnt + CW'(1);
            end
            if (commit) begin
                active <= shadow_nxt;
            end
        end
    end

    // A fresh config must never see state left by the old function.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            flops <= '0;
        end else if (commit) begin
            flops <= '0;
        end else if (run_en) begin
            flops <= sum;
        end
    end

    assign vars = {flops, INPUT_VARS};

    always_comb begin
        prod    = '0;
        lit_any = '0;
        for (int p = 0; p < P; p++) begin
            prod[p] = 1'b1;
            for (int v = 0; v < V; v++) begin
                if (active[p*2*V + 2*v]) begin
                    lit_any[p] = 1'b1;
                    if (!vars[v]) prod[p] = 1'b0;
                end
                if (active[p*2*V + 2*v + 1]) begin
                    lit_any[p] = 1'b1;
                    if (vars[v]) prod[p] = 1'b0;
                end
            end
            prod[p] = prod[p] & lit_any[p];
        end
    end

    always_comb begin
        sum         = '0;
        OUTPUT_VALS = '0;
        for (int m = 0; m < M; m++) begin
            sum[m]         = |(active[A + m*P +: P] & prod);
            OUTPUT_VALS[m] = (active[B + 2*m] ? flops[m] : sum[m]) ^ active[B + 2*m + 1];
        end
    end
endmodule

// File: tb/tb_pal_macrocell_fabric.sv
// Directed bench for pal_macrocell_fabric: expected {cfg_done, cfg_busy, OUTPUT_VALS} queued per step and compared as the DUT settles.
module tb_pal_macrocell_fabric;
    localparam int L = 372;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       cfg_en = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       run_en = 1'b0;
    logic [7:0] in_vars = 8'h00;
    logic [3:0] out_vals;
    logic       busy;
    logic       done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string      tag;
        logic [5:0] val;
    } exp_t;
    exp_t sb[$];

    logic [L-1:0] f_and, f_tog, f_tog_inv, f_inv, f_inv2;

    always #5 clk = ~clk;

    pal_macrocell_fabric dut (
        .clk        (clk),
        .res_n      (res_n),
        .cfg_en     (cfg_en),
        .cfg_bit    (cfg_bit),
        .run_en     (run_en),
        .INPUT_VARS (in_vars),
        .OUTPUT_VALS(out_vals),
        .cfg_busy   (busy),
        .cfg_done   (done)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string tag, input logic d, input logic b, input logic [3:0] o);
        exp_t e;
        e.tag = tag;
        e.val = {d, b, o};
        sb.push_back(e);
    endtask

    task automatic compare_pending();
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            logic [5:0] obs;
            e   = sb.pop_front();
            obs = {done, busy, out_vals};
            n_total++;
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s observed(done,busy,out)=%b expected=%b", e.tag, obs, e.val);
        end
    endtask

    task automatic check(input string tag, input logic d, input logic b, input logic [3:0] o);
        expect_now(tag, d, b, o);
        compare_pending();
    endtask

    // Shifts bits [0, nbits) of f; with live set, checks the old function persists while busy.
    task automatic send_frame(input logic [L-1:0] f, input int nbits, input bit live,
                              input logic [3:0] live_out);
        for (int k = 0; k < nbits; k++) begin
            cfg_en  = 1'b1;
            cfg_bit = f[k];
            tick();
            if (live && k < L - 1) check("live_reload", 1'b0, 1'b1, live_out);
        end
        cfg_en  = 1'b0;
        cfg_bit = 1'b0;
    endtask

    initial begin
        f_and = '0;
        f_and[0] = 1'b1; f_and[2] = 1'b1; f_and[312] = 1'b1;
        f_tog = '0;
        f_tog[43] = 1'b1; f_tog[326] = 1'b1; f_tog[366] = 1'b1;
        f_tog_inv = f_tog;
        f_tog_inv[367] = 1'b1;
        f_inv = '0;
        f_inv[365] = 1'b1;
        f_inv2 = f_inv;
        f_inv2[0] = 1'b1; f_inv2[1] = 1'b1; f_inv2[312] = 1'b1;

        // Reset with arbitrary activity on every input.
        res_n   = 1'b0;
        in_vars = 8'($urandom);
        cfg_en  = 1'b1;
        cfg_bit = 1'b1;
        run_en  = 1'b1;
        check("reset_hold", 1'b0, 1'b0, 4'h0);
        tick();
        in_vars = 8'($urandom);
        check("reset_clocked", 1'b0, 1'b0, 4'h0);
        cfg_en = 1'b0;
        run_en = 1'b0;
        res_n  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_idle", 1'b0, 1'b0, 4'h0);
        end

        // AND gate on inputs 0 and 1, combinational on output 0.
        in_vars = 8'h03;
        send_frame(f_and, L, 1'b0, 4'h0);
        check("and_commit_done", 1'b1, 1'b0, 4'h1);
        tick();
        check("and_done_drops", 1'b0, 1'b0, 4'h1);
        in_vars = 8'h01;
        check("and_in01", 1'b0, 1'b0, 4'h0);
        in_vars = 8'h02;
        check("and_in02", 1'b0, 1'b0, 4'h0);
        in_vars = 8'hFF;
        check("and_inFF", 1'b0, 1'b0, 4'h1);
        in_vars = 8'h03;
        check("and_in03", 1'b0, 1'b0, 4'h1);

        // Live reload into the toggle frame while the AND function keeps running.
        send_frame(f_tog, L, 1'b1, 4'h1);
        check("tog_commit", 1'b1, 1'b0, 4'h0);
        run_en = 1'b1;
        tick();
        check("tog_seq1", 1'b0, 1'b0, 4'h2);
        tick();
        check("tog_seq2", 1'b0, 1'b0, 4'h0);
        tick();
        check("tog_seq3", 1'b0, 1'b0, 4'h2);
        run_en = 1'b0;
        tick();
        check("tog_hold1", 1'b0, 1'b0, 4'h2);
        tick();
        check("tog_hold2", 1'b0, 1'b0, 4'h2);

        // Inverted toggle loaded while the flop keeps toggling; commit clear wins over run_en.
        run_en = 1'b1;
        send_frame(f_tog_inv, L, 1'b0, 4'h0);
        check("toginv_commit", 1'b1, 1'b0, 4'h2);
        tick();
        check("toginv_seq1", 1'b0, 1'b0, 4'h0);
        tick();
        check("toginv_seq2", 1'b0, 1'b0, 4'h2);
        tick();
        check("toginv_seq3", 1'b0, 1'b0, 4'h0);
        run_en = 1'b0;

        // Inverted empty sum, then inverted contradictory product.
        send_frame(f_inv, L, 1'b0, 4'h0);
        check("inv_commit", 1'b1, 1'b0, 4'h1);
        tick();
        in_vars = 8'h00;
        check("inv_in00", 1'b0, 1'b0, 4'h1);
        in_vars = 8'hFF;
        check("inv_inFF", 1'b0, 1'b0, 4'h1);
        in_vars = 8'hA5;
        check("inv_inA5", 1'b0, 1'b0, 4'h1);
        send_frame(f_inv2, L, 1'b0, 4'h0);
        tick();
        in_vars = 8'h01;
        check("inv2_in01", 1'b0, 1'b0, 4'h1);
        in_vars = 8'h00;
        check("inv2_in00", 1'b0, 1'b0, 4'h1);
        in_vars = 8'hFF;
        check("inv2_inFF", 1'b0, 1'b0, 4'h1);

        // Reset in the middle of a frame discards everything.
        in_vars = 8'h03;
        send_frame(f_and, L, 1'b0, 4'h0);
        tick();
        send_frame(f_tog, 100, 1'b0, 4'h0);
        check("midload_busy", 1'b0, 1'b1, 4'h1);
        res_n = 1'b0;
        check("midload_reset", 1'b0, 1'b0, 4'h0);
        tick();
        res_n = 1'b1;
        tick();
        check("midload_after", 1'b0, 1'b0, 4'h0);
        send_frame(f_and, L, 1'b0, 4'h0);
        check("reload_commit", 1'b1, 1'b0, 4'h1);
        tick();
        in_vars = 8'h02;
        check("reload_in02", 1'b0, 1'b0, 4'h0);
        in_vars = 8'h03;
        check("reload_in03", 1'b0, 1'b0, 4'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
